// File: rtl/ib_pkg.sv
// Shared types for the instruction buffer: warp count and the decoded entry layout.
package ib_pkg;

  localparam int unsigned NUM_WARPS = 8;

  typedef struct packed {
    logic [31:0] Instr;
    logic [4:0]  Src1;
    logic [4:0]  Src2;
    logic [4:0]  Dst;
    logic [15:0] Imme;
    logic        Src1_Valid;
    logic        Src2_Valid;
    logic        Imme_Valid;
    logic [3:0]  ALUop;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        Shared_Globalbar;
    logic        BEQ;
    logic        BLT;
    logic        Exit;
  } ib_entry_t;

  localparam int unsigned ENTRY_W = $bits(ib_entry_t);

endpackage

// File: rtl/ib_warp_fifo.sv
// One warp's circular instruction FIFO: storage, pointers, occupancy and sticky overflow.
// Optional IB_BYPASS_EN: a write into an empty FIFO is visible at the head in the same cycle.
module ib_warp_fifo
  import ib_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr0,
  input  logic                      i_wr1,
  input  ib_entry_t                 i_entry0,
  input  ib_entry_t                 i_entry1,
  input  logic                      i_pop,
  input  logic                      i_flush,
  output ib_entry_t                 o_head,
  output logic                      o_head_valid,
  output logic [$clog2(DEPTH):0]    o_occ_next,
  output logic                      o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ib_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_occ;
  logic          r_ovf;

  logic          w_pop_mem;
  logic          w_st0;
  logic          w_st1;
  logic          w_acc0;
  logic          w_acc1;
  logic          w_ovf_set;
  logic [CW-1:0] w_free;
  logic [AW-1:0] w_wr1_ptr;

`ifdef IB_BYPASS_EN
  logic w_empty;
  logic w_byp_pop;

  assign w_empty = (r_occ == '0);

  always_comb begin
    o_head_valid = !w_empty || i_wr0 || i_wr1;
    o_head       = r_mem[r_rd];
    if (w_empty) begin
      o_head = i_wr0 ? i_entry0 : i_entry1;
    end
  end

  // A pop on an empty warp takes the first incoming write; only the remainder is stored.
  assign w_byp_pop = w_empty && i_pop && (i_wr0 || i_wr1);
  assign w_pop_mem = i_pop && !w_empty;
  assign w_st0     = i_wr0 && !w_byp_pop;
  assign w_st1     = i_wr1 && !(w_byp_pop && !i_wr0);
`else
  assign o_head_valid = (r_occ != '0);
  assign o_head       = r_mem[r_rd];
  assign w_pop_mem    = i_pop && o_head_valid;
  assign w_st0        = i_wr0;
  assign w_st1        = i_wr1;
`endif

  // Free space counts the same-cycle pop; ID1 only lands if ID0 left room.
  assign w_free    = CW'(DEPTH) - r_occ + CW'(w_pop_mem);
  assign w_acc0    = w_st0 && (w_free != '0);
  assign w_acc1    = w_st1 && (w_free > CW'(w_acc0));
  assign w_ovf_set = (w_st0 && !w_acc0) || (w_st1 && !w_acc1);
  assign w_wr1_ptr = r_wr + AW'(w_acc0);

  assign o_occ_next = i_flush ? '0
                    : r_occ + CW'(w_acc0) + CW'(w_acc1) - CW'(w_pop_mem);
  assign o_overflow = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_occ <= '0;
      r_ovf <= 1'b0;
    end else if (i_flush) begin
      r_rd  <= r_wr;
      r_occ <= '0;
    end else begin
      r_rd  <= r_rd + AW'(w_pop_mem);
      r_wr  <= r_wr + AW'(w_acc0) + AW'(w_acc1);
      r_occ <= o_occ_next;
      r_ovf <= r_ovf | w_ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !i_flush) begin
      if (w_acc0) r_mem[r_wr]      <= i_entry0;
      if (w_acc1) r_mem[w_wr1_ptr] <= i_entry1;
    end
  end

endmodule

// File: rtl/ibuffer.sv
// Per-warp instruction buffer between decode and issue, with registered fetch requests.
// Optional IB_BYPASS_EN enables same-cycle write-to-head bypass in each warp FIFO.
module ibuffer
  import ib_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SKID  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WARPS-1:0]           Valid_ID0_IB_SIMT,
  input  logic [NUM_WARPS-1:0]           Valid_ID1_IB_SIMT,
  input  ib_entry_t                      Entry_ID0_IB,
  input  ib_entry_t                      Entry_ID1_IB,
  input  logic [NUM_WARPS-1:0]           Flush_SIMT_IB,
  input  logic [NUM_WARPS-1:0]           Issue_IS_IB,
  output logic [NUM_WARPS-1:0]           Req_IB_PC,
  output logic [NUM_WARPS-1:0]           HeadValid_IB_IS,
  output logic [NUM_WARPS*ENTRY_W-1:0]   Head_IB_IS_Flattened,
  output logic [NUM_WARPS-1:0]           Overflow_IB
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [NUM_WARPS-1:0] r_req;
  logic [NUM_WARPS-1:0] w_issue;
  logic [CW-1:0]        w_occ_nx [NUM_WARPS];
  ib_entry_t            w_head   [NUM_WARPS];

  // Keep only the lowest set issue bit.
  assign w_issue = Issue_IS_IB & (-Issue_IS_IB);

  for (genvar gw = 0; gw < NUM_WARPS; gw++) begin : g_warp
    ib_warp_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_wr0        (Valid_ID0_IB_SIMT[gw]),
      .i_wr1        (Valid_ID1_IB_SIMT[gw]),
      .i_entry0     (Entry_ID0_IB),
      .i_entry1     (Entry_ID1_IB),
      .i_pop        (w_issue[gw]),
      .i_flush      (Flush_SIMT_IB[gw]),
      .o_head       (w_head[gw]),
      .o_head_valid (HeadValid_IB_IS[gw]),
      .o_occ_next   (w_occ_nx[gw]),
      .o_overflow   (Overflow_IB[gw])
    );
    assign Head_IB_IS_Flattened[gw*ENTRY_W +: ENTRY_W] = w_head[gw];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        r_req[w] <= !Flush_SIMT_IB[w] &&
                    ((int'(DEPTH) - int'(w_occ_nx[w])) >= int'(SKID));
      end
    end
  end

  assign Req_IB_PC = r_req;

endmodule

// File: tb/tb_ibuffer.sv
// Self-checking bench for ibuffer: queue model compared every cycle plus directed literal checks.
module tb_ibuffer;
  import ib_pkg::*;

  localparam int DEPTH = 4;
  localparam int SKID  = 4;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [7:0]                    v0, v1, fl, iss;
  ib_entry_t                     e0, e1;
  logic [7:0]                    req, hv, ovf;
  logic [NUM_WARPS*ENTRY_W-1:0]  headf;

  int checks = 0;
  int errors = 0;

  ibuffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .Valid_ID0_IB_SIMT    (v0),
    .Valid_ID1_IB_SIMT    (v1),
    .Entry_ID0_IB         (e0),
    .Entry_ID1_IB         (e1),
    .Flush_SIMT_IB        (fl),
    .Issue_IS_IB          (iss),
    .Req_IB_PC            (req),
    .HeadValid_IB_IS      (hv),
    .Head_IB_IS_Flattened (headf),
    .Overflow_IB          (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic ib_entry_t mk(input logic [31:0] i);
    ib_entry_t e;
    e        = '0;
    e.Instr  = i;
    e.Dst    = i[4:0];
    e.Src1   = i[9:5];
    e.Imme   = i[31:16];
    e.ALUop  = i[3:0];
    e.Exit   = i[0];
    return e;
  endfunction

  function automatic ib_entry_t head_of(input int w);
    return ib_entry_t'(headf[w*ENTRY_W +: ENTRY_W]);
  endfunction

  // Behavioural model: each warp is an ordered list, shifted down on pop.
  ib_entry_t  mq [8][DEPTH];
  int         mcnt [8];
  logic [7:0] mreq = '0;
  logic [7:0] movf = '0;
  bit         chk_en = 1'b0;
  ib_entry_t  inc [2];
  int         ninc;
  int         sel;

  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 8; w++) mcnt[w] = 0;
      mreq = '0;
      movf = '0;
    end else begin
      sel = -1;
      for (int w = 0; w < 8; w++) if (iss[w] && sel < 0) sel = w;
      for (int w = 0; w < 8; w++) begin
        if (fl[w]) begin
          mcnt[w] = 0;
          mreq[w] = 1'b0;
        end else begin
          ninc = 0;
          if (v0[w]) begin inc[ninc] = e0; ninc++; end
          if (v1[w]) begin inc[ninc] = e1; ninc++; end
          if (sel == w) begin
            if (mcnt[w] > 0) begin
              for (int k = 0; k < DEPTH - 1; k++) mq[w][k] = mq[w][k+1];
              mcnt[w]--;
            end
`ifdef IB_BYPASS_EN
            else if (ninc > 0) begin
              inc[0] = inc[1];
              ninc--;
            end
`endif
          end
          for (int k = 0; k < ninc; k++) begin
            if (mcnt[w] < DEPTH) begin
              mq[w][mcnt[w]] = inc[k];
              mcnt[w]++;
            end else begin
              movf[w] = 1'b1;
            end
          end
          mreq[w] = (DEPTH - mcnt[w]) >= SKID;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] ehv;
    ib_entry_t  eh;
    if (chk_en) begin
      for (int w = 0; w < 8; w++) begin
        ehv[w] = (mcnt[w] > 0);
`ifdef IB_BYPASS_EN
        if (v0[w] || v1[w]) ehv[w] = 1'b1;
`endif
      end
      chk("model_headvalid", 128'(hv), 128'(ehv));
      chk("model_req", 128'(req), 128'(mreq));
      chk("model_overflow", 128'(ovf), 128'(movf));
      for (int w = 0; w < 8; w++) begin
        if (ehv[w]) begin
          eh = (mcnt[w] > 0) ? mq[w][0] : (v0[w] ? e0 : e1);
          chk($sformatf("model_head_w%0d", w), 128'(head_of(w)), 128'(eh));
        end
      end
    end
  end

  task automatic step(input logic [7:0] a0, input ib_entry_t x0,
                      input logic [7:0] a1, input ib_entry_t x1,
                      input logic [7:0] f,  input logic [7:0] is);
    v0 = a0; e0 = x0; v1 = a1; e1 = x1; fl = f; iss = is;
    @(posedge clk);
    #1;
    v0 = '0; v1 = '0; fl = '0; iss = '0; e0 = '0; e1 = '0;
  endtask

  initial begin
    rst = 1'b1; v0 = '0; v1 = '0; fl = '0; iss = '0; e0 = '0; e1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_req", 128'(req), 128'h00);
    chk("reset_hv", 128'(hv), 128'h00);
    chk("reset_ovf", 128'(ovf), 128'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", 128'(req), 128'hFF);
    chk("first_hv", 128'(hv), 128'h00);

    // single write to warp 2
    step(8'h04, mk(32'h1234_0001), 8'h00, '0, 8'h00, 8'h00);
    @(negedge clk);
    chk("w2_hv", 128'(hv[2]), 128'h1);
    chk("w2_instr", 128'(head_of(2).Instr), 128'h1234_0001);
    chk("w2_req", 128'(req[2]), 128'h0);

    // dual write to warp 5, then two pops
    step(8'h20, mk(32'hA5A5_000A), 8'h20, mk(32'hB5B5_000B), 8'h00, 8'h00);
    @(negedge clk);
    chk("w5_headA", 128'(head_of(5).Instr), 128'hA5A5_000A);
    step(8'h00, '0, 8'h00, '0, 8'h00, 8'h20);
    @(negedge clk);
    chk("w5_headB", 128'(head_of(5).Instr), 128'hB5B5_000B);
    step(8'h00, '0, 8'h00, '0, 8'h00, 8'h20);
    @(negedge clk);
    chk("w5_empty", 128'(hv[5]), 128'h0);
    chk("w5_req", 128'(req[5]), 128'h1);

    // fill warp 0 then overflow
    step(8'h01, mk(32'hE000_0000), 8'h01, mk(32'hE000_0001), 8'h00, 8'h00);
    step(8'h01, mk(32'hE000_0002), 8'h01, mk(32'hE000_0003), 8'h00, 8'h00);
    @(negedge clk);
    chk("w0_full_noovf", 128'(ovf[0]), 128'h0);
    step(8'h01, mk(32'hE000_0004), 8'h00, '0, 8'h00, 8'h00);
    @(negedge clk);
    chk("w0_ovf", 128'(ovf[0]), 128'h1);
    chk("w0_head_kept", 128'(head_of(0).Instr), 128'hE000_0000);

    // full warp with pop: ID0 fits, ID1 dropped
    step(8'h01, mk(32'hE000_0005), 8'h01, mk(32'hE000_0006), 8'h00, 8'h01);
    @(negedge clk);
    chk("w0_pop_head", 128'(head_of(0).Instr), 128'hE000_0001);

    // flush warp 3 at occ=2 with same-cycle write
    step(8'h08, mk(32'hF000_0000), 8'h08, mk(32'hF000_0001), 8'h00, 8'h00);
    step(8'h08, mk(32'hF000_0002), 8'h00, '0, 8'h08, 8'h00);
    @(negedge clk);
    chk("w3_flush_hv", 128'(hv[3]), 128'h0);
    chk("w3_flush_req", 128'(req[3]), 128'h0);
    step(8'h00, '0, 8'h00, '0, 8'h00, 8'h00);
    @(negedge clk);
    chk("w3_req_back", 128'(req[3]), 128'h1);

    // warp 7 wraparound with write/pop pairs
    step(8'h80, mk(32'h7000_0000), 8'h00, '0, 8'h00, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      step(8'h80, mk(32'h7000_0000 + k), 8'h00, '0, 8'h00, 8'h80);
      @(negedge clk);
      chk($sformatf("w7_wrap_%0d", k), 128'(head_of(7).Instr), 128'(32'h7000_0000 + k));
    end
    step(8'h00, '0, 8'h00, '0, 8'h00, 8'h80);
    @(negedge clk);
    chk("w7_drained", 128'(hv[7]), 128'h0);
    step(8'h80, mk(32'h7000_0009), 8'h00, '0, 8'h00, 8'h80);
    @(negedge clk);
`ifdef IB_BYPASS_EN
    chk("w7_bypass_consumed", 128'(hv[7]), 128'h0);
`else
    chk("w7_pop_empty_ignored", 128'(hv[7]), 128'h1);
    step(8'h00, '0, 8'h00, '0, 8'h00, 8'h80);
`endif

    // multi-bit issue only serves lowest warp
    step(8'h20, mk(32'h5000_0001), 8'h00, '0, 8'h00, 8'h00);
    step(8'h00, '0, 8'h00, '0, 8'h00, 8'h24);
    @(negedge clk);
    chk("multi_issue_w2", 128'(hv[2]), 128'h0);
    chk("multi_issue_w5", 128'(head_of(5).Instr), 128'h5000_0001);

    // ID1-only write
    step(8'h00, '0, 8'h10, mk(32'h4000_0001), 8'h00, 8'h00);
    @(negedge clk);
    chk("id1_only", 128'(head_of(4).Instr), 128'h4000_0001);

    // reset mid-operation discards the cycle's activity
    rst = 1'b1;
    step(8'h02, mk(32'h2000_0001), 8'h00, '0, 8'h00, 8'h20);
    @(negedge clk);
    chk("midrst_hv", 128'(hv), 128'h00);
    chk("midrst_req", 128'(req), 128'h00);
    chk("midrst_ovf", 128'(ovf), 128'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_back", 128'(req), 128'hFF);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
